// File: rtl/typer_pkg.sv
// rtl/typer_pkg.sv - shared types, widths and helpers for the character-typer scheduler
package typer_pkg;

    localparam int CHAR_W   = 8;
    localparam int ROWCOL_W = 8;
    localparam int CNT_W    = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } sched_state_t;

    // Completed-character counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting one past the last winner
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    // Scan rr_ptr+1, rr_ptr+2, ... wrapping, and take the first asserted request.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/typer_char_scheduler.sv
// rtl/typer_char_scheduler.sv - round-robin sharing of the character typer; optional watchdog under TYPER_SCHED_TIMEOUT_EN
module typer_char_scheduler
    import typer_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [ROWCOL_W*NUM_REQ-1:0] row_in,
    input  logic [ROWCOL_W*NUM_REQ-1:0] col_in,
    input  logic [CHAR_W*NUM_REQ-1:0]   char_in,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic [ROWCOL_W-1:0]         typer_row,
    output logic [ROWCOL_W-1:0]         typer_col,
    output logic [CHAR_W-1:0]           typer_char,
    output logic                        typer_start,
    input  logic                        typer_done,
    output logic [CNT_W-1:0]            chars_written,
    output logic                        timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("NUM_REQ must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    sched_state_t       state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   pick;
    logic               pick_valid;
    logic [NUM_REQ-1:0] win_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    assign busy       = (state != ST_IDLE);

`ifdef TYPER_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Sequencer: latch a winner, pulse start, wait for done, acknowledge the winner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= PTR_W'(NUM_REQ - 1);
            winner        <= '0;
            grant         <= '0;
            typer_row     <= '0;
            typer_col     <= '0;
            typer_char    <= '0;
            typer_start   <= 1'b0;
            chars_written <= '0;
`ifdef TYPER_SCHED_TIMEOUT_EN
            wd_cnt        <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            typer_start <= 1'b0;
            grant       <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        typer_row   <= row_in[int'(pick)*ROWCOL_W +: ROWCOL_W];
                        typer_col   <= col_in[int'(pick)*ROWCOL_W +: ROWCOL_W];
                        typer_char  <= char_in[int'(pick)*CHAR_W +: CHAR_W];
                        winner      <= pick;
                        typer_start <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A done here cannot belong to this character; it is dropped.
                    state <= ST_WAIT;
`ifdef TYPER_SCHED_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (typer_done) begin
                        state         <= ST_ACK;
                        grant         <= win_onehot;
                        rr_ptr        <= winner;
                        chars_written <= sat_inc(chars_written);
                    end
`ifdef TYPER_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        // Release the requester so the HUD never stalls; nothing was written.
                        state       <= ST_ACK;
                        grant       <= win_onehot;
                        rr_ptr      <= winner;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_typer_char_scheduler.sv
// tb/tb_typer_char_scheduler.sv - self-checking bench for typer_char_scheduler
module tb_typer_char_scheduler;

`ifdef TYPER_SCHED_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 4096;
`endif
    localparam int N = 4;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req     = '0;
    logic [31:0] row_in  = '0;
    logic [31:0] col_in  = '0;
    logic [31:0] char_in = '0;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  typer_row;
    logic [7:0]  typer_col;
    logic [7:0]  typer_char;
    logic        typer_start;
    logic        typer_done;
    logic [15:0] chars_written;
    logic        timeout_err;

    logic resp_done = 1'b0;
    logic inj_done  = 1'b0;
    int   typer_lat = 0;
    int   resp_cnt  = 0;
    assign typer_done = resp_done | inj_done;

    int n_checks  = 0;
    int n_fail    = 0;
    int edge_no   = 0;
    int done_edge = -1;

    logic [3:0] exp_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // model state: one transaction in flight, timed by edges since its latch
    bit         m_inflight = 0;
    bit         m_acking   = 0;
    int         m_age      = 0;
    int         m_win      = 0;
    int         m_ptr      = N - 1;
    logic [7:0] m_row      = '0;
    logic [7:0] m_col      = '0;
    logic [7:0] m_char     = '0;
    int         m_count    = 0;
    logic [3:0] m_grant    = '0;
    bit         m_terr     = 0;

    typer_char_scheduler #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .row_in        (row_in),
        .col_in        (col_in),
        .char_in       (char_in),
        .grant         (grant),
        .busy          (busy),
        .typer_row     (typer_row),
        .typer_col     (typer_col),
        .typer_char    (typer_char),
        .typer_start   (typer_start),
        .typer_done    (typer_done),
        .chars_written (chars_written),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // typer stand-in: done pulse typer_lat cycles after start; 0 means never
    always @(negedge clock) begin
        resp_done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) resp_done = 1'b1;
        end
        if (typer_start && typer_lat > 0) resp_cnt = typer_lat;
    end

    task automatic model_step();
        m_grant = '0;
        if (!reset_n) begin
            m_inflight = 0; m_acking = 0; m_age = 0; m_ptr = N - 1;
            m_row = '0; m_col = '0; m_char = '0; m_count = 0; m_terr = 0;
        end else if (m_inflight) begin
            if (m_acking) begin
                m_inflight = 0;
                m_acking   = 0;
            end else if (m_age >= 2) begin
                if (typer_done) begin
                    m_acking = 1;
                    m_grant  = 4'(1 << m_win);
                    m_ptr    = m_win;
                    if (m_count < 65535) m_count++;
                end
`ifdef TYPER_SCHED_TIMEOUT_EN
                else if (m_age - 1 == TB_TIMEOUT) begin
                    m_acking = 1;
                    m_grant  = 4'(1 << m_win);
                    m_ptr    = m_win;
                    m_terr   = 1;
                end
`endif
            end
            m_age++;
        end else if (req != 0) begin
            for (int off = 1; off <= N; off++) begin
                int idx;
                idx = (m_ptr + off) % N;
                if (!m_inflight && req[idx]) begin
                    m_inflight = 1;
                    m_win      = idx;
                end
            end
            m_row  = row_in[m_win*8 +: 8];
            m_col  = col_in[m_win*8 +: 8];
            m_char = char_in[m_win*8 +: 8];
            m_age  = 1;
        end
    endtask

    // model update on each edge, output comparison 2 time units later
    initial begin
        forever begin
            @(posedge clock);
            edge_no++;
            if (typer_done) done_edge = edge_no;
            model_step();
            #2;
            check("busy",          32'(busy),          32'(m_inflight));
            check("typer_start",   32'(typer_start),   32'(m_inflight && m_age == 1));
            check("grant",         32'(grant),         32'(m_grant));
            check("chars_written", 32'(chars_written), m_count);
            check("timeout_err",   32'(timeout_err),   32'(m_terr));
            check("typer_row",     32'(typer_row),     32'(m_row));
            check("typer_col",     32'(typer_col),     32'(m_col));
            check("typer_char",    32'(typer_char),    32'(m_char));
        end
    end

    task automatic tick();
        @(posedge clock);
        #3;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output logic [3:0] g, output int ge);
        g  = '0;
        ge = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (grant != 0) begin
                g  = grant;
                ge = edge_no;
                break;
            end
        end
        if (ge < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_grant: no grant within %0d cycles", budget);
        end
    endtask

    task automatic wait_start(input int budget, output int se);
        se = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (typer_start) begin
                se = edge_no;
                break;
            end
        end
        if (se < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_start: no start within %0d cycles", budget);
        end
    endtask

    initial begin
        logic [3:0] g;
        int         ge, se, req_edge, prev_ge, c0, stray;

        // reset values
        tick();
        check("rst_busy",  32'(busy),          0);
        check("rst_grant", 32'(grant),         0);
        check("rst_start", 32'(typer_start),   0);
        check("rst_count", 32'(chars_written), 0);
        check("rst_row",   32'(typer_row),     0);
        check("rst_terr",  32'(timeout_err),   0);
        reset_n = 1'b1;
        tick();

        // single character from requester 0, typer answers 10 cycles after start
        typer_lat     = 10;
        row_in[7:0]   = 8'd3;
        col_in[7:0]   = 8'd5;
        char_in[7:0]  = 8'h41;
        req           = 4'b0001;
        req_edge      = edge_no + 1;
        wait_start(10, se);
        check("t1_start_lat", se, req_edge);
        check("t1_row",  32'(typer_row),  3);
        check("t1_col",  32'(typer_col),  5);
        check("t1_char", 32'(typer_char), 32'h41);
        wait_grant(40, g, ge);
        req = '0;
        check("t1_grant",     32'(g), 32'b0001);
        check("t1_done_edge", done_edge, se + 11);
        check("t1_grant_lat", ge, done_edge);
        check("t1_count",     32'(chars_written), 1);
        tick();
        check("t1_grant_one_cycle", 32'(grant), 0);

        // all four requesting: strict rotation from pointer 3
        apply_reset();
        typer_lat = 1;
        row_in    = 32'h44332211;
        col_in    = 32'h88776655;
        char_in   = 32'h64636261;
        req       = 4'b1111;
        prev_ge   = -1;
        for (int i = 0; i < 8; i++) begin
            wait_grant(20, g, ge);
            check($sformatf("t2_grant_%0d", i), 32'(g), 32'(exp_seq[i]));
            if (prev_ge >= 0) check($sformatf("t2_spacing_%0d", i), ge - prev_ge, 4);
            prev_ge = ge;
        end
        req = '0;
        check("t2_count", 32'(chars_written), 8);
        tick();
        tick();

        // after requester 1 wins, requester 0 is next even though 1 still asks
        apply_reset();
        typer_lat = 2;
        req       = 4'b0010;
        wait_grant(20, g, ge);
        check("t3_first", 32'(g), 32'b0010);
        req = 4'b0011;
        wait_grant(20, g, ge);
        check("t3_second", 32'(g), 32'b0001);
        wait_grant(20, g, ge);
        check("t3_third", 32'(g), 32'b0010);
        req = '0;
        tick();
        tick();

        // stray done while idle and during the issue cycle
        c0       = chars_written;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        check("t4_idle_busy",  32'(busy),          0);
        check("t4_idle_grant", 32'(grant),         0);
        check("t4_idle_count", 32'(chars_written), c0);
        typer_lat = 0;
        req       = 4'b0001;
        wait_start(10, se);
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        stray    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant != 0 || !busy) stray++;
        end
        check("t4_issue_done_ignored", stray, 0);
        check("t4_issue_count", 32'(chars_written), c0);
        inj_done = 1'b1;
        wait_grant(5, g, ge);
        inj_done = 1'b0;
        req      = '0;
        check("t4_grant", 32'(g), 32'b0001);
        check("t4_count", 32'(chars_written), c0 + 1);
        tick();
        tick();

        // reset while waiting on the typer
        req = 4'b0100;
        wait_start(10, se);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("t5_async_busy",  32'(busy),        0);
        check("t5_async_start", 32'(typer_start), 0);
        check("t5_async_grant", 32'(grant),       0);
        req = '0;
        tick();
        check("t5_no_grant", 32'(grant), 0);
        reset_n   = 1'b1;
        typer_lat = 1;
        req       = 4'b1111;
        wait_grant(20, g, ge);
        req = '0;
        check("t5_ptr_restart", 32'(g), 32'b0001);
        tick();
        tick();

`ifdef TYPER_SCHED_TIMEOUT_EN
        // typer never answers: watchdog releases the requester
        apply_reset();
        typer_lat = 0;
        req       = 4'b0001;
        wait_start(10, se);
        tick();
        check("t6_terr_before", 32'(timeout_err), 0);
        wait_grant(40, g, ge);
        req = '0;
        check("t6_grant",   32'(g), 32'b0001);
        check("t6_latency", ge - se, 17);
        check("t6_terr",    32'(timeout_err), 1);
        check("t6_count",   32'(chars_written), 0);
        tick();
        typer_lat = 3;
        req       = 4'b0010;
        wait_grant(20, g, ge);
        req = '0;
        check("t6_next_grant", 32'(g), 32'b0010);
        check("t6_next_count", 32'(chars_written), 1);
        check("t6_terr_sticky", 32'(timeout_err), 1);
        tick();
`else
        check("t6_terr_tied", 32'(timeout_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // hard stop in case a stimulus loop is mis-bounded
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
